// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch-squash / MDU sequencing hazard controller for the 5-stage core.
// Optional HAZARD_PERF_EN adds saturating stall and flush perf counters.
module hazard_stall_ctrl #(
  parameter int MDU_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_mdu_start,
  input  logic        id_mdu_read,
  input  logic        ex_memrd,
  input  logic [4:0]  ex_regrd,
  input  logic        branch_taken,
  output logic        pc_wr,
  output logic        ifid_wr,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        mdu_go,
  output logic        mdu_busy,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam int CW = $clog2(MDU_CYCLES + 1);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MDU_BUSY = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          lu;
  logic          ms;
  logic          stall;

  assign busy = (state == MDU_BUSY);

  assign lu = ex_memrd && (ex_regrd != 5'd0) &&
              ((id_use_rs && (ex_regrd == id_rs)) ||
               (id_use_rt && (ex_regrd == id_rt)));

  assign ms    = busy && (id_mdu_read || id_mdu_start);
  assign stall = lu || ms;

  assign mdu_busy = busy && !rst;

  always_comb begin
    pc_wr      = 1'b1;
    ifid_wr    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    mdu_go     = 1'b0;
    if (rst) begin
      pc_wr      = 1'b0;
      ifid_wr    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (branch_taken) begin
      // the stalled ID instruction is wrong-path, so squash wins
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (stall) begin
      pc_wr      = 1'b0;
      ifid_wr    = 1'b0;
      idex_flush = 1'b1;
    end else begin
      mdu_go = id_mdu_start;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else if (state == RUN) begin
      if (mdu_go) begin
        state <= MDU_BUSY;
        cnt   <= CW'(MDU_CYCLES);
      end
    end else begin
      if (cnt == CW'(1)) state <= RUN;
      cnt <= cnt - CW'(1);
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] sc_q;
  logic [31:0] fc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q <= '0;
      fc_q <= '0;
    end else begin
      if (stall && !branch_taken && (sc_q != 32'hFFFF_FFFF))
        sc_q <= sc_q + 32'd1;
      if (branch_taken && (fc_q != 32'hFFFF_FFFF))
        fc_q <= fc_q + 32'd1;
    end
  end

  assign stall_cycles = rst ? 32'd0 : sc_q;
  assign flush_count  = rst ? 32'd0 : fc_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed scenarios then random traffic.
// A cycle-indexed reference model pushes expectations; a negedge monitor checks them.
module tb_hazard_stall_ctrl;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_regrd;
  logic        id_use_rs, id_use_rt;
  logic        id_mdu_start, id_mdu_read;
  logic        ex_memrd, branch_taken;
  logic        pc_wr, ifid_wr, ifid_flush, idex_flush;
  logic        mdu_go, mdu_busy;
  logic [31:0] stall_cycles, flush_count;

  typedef struct {
    logic [5:0]  ctrl;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int fails  = 0;

  // model state: cycle index and last cycle the MDU is busy
  longint cyc      = 0;
  longint busy_end = -1;
  longint m_sc     = 0;
  longint m_fc     = 0;

  hazard_stall_ctrl #(.MDU_CYCLES(N)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_mdu_start(id_mdu_start), .id_mdu_read(id_mdu_read),
    .ex_memrd(ex_memrd), .ex_regrd(ex_regrd),
    .branch_taken(branch_taken),
    .pc_wr(pc_wr), .ifid_wr(ifid_wr),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mdu_go(mdu_go), .mdu_busy(mdu_busy),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] perf(input longint v);
`ifdef HAZARD_PERF_EN
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
`else
    return (v < 0) ? 32'd1 : 32'd0;
`endif
  endfunction

  task automatic step(
    input logic r, input logic [4:0] rs, input logic [4:0] rt,
    input logic urs, input logic urt, input logic st, input logic rd,
    input logic mem, input logic [4:0] dst, input logic br);
    exp_t e;
    bit busy, lu, stall;
    @(posedge clk);
    #1;
    rst = r; id_rs = rs; id_rt = rt;
    id_use_rs = urs; id_use_rt = urt;
    id_mdu_start = st; id_mdu_read = rd;
    ex_memrd = mem; ex_regrd = dst; branch_taken = br;
    busy  = (cyc <= busy_end);
    lu    = mem && dst != 0 &&
            ((urs && dst == rs) || (urt && dst == rt));
    stall = lu || (busy && (rd || st));
    // ctrl = {pc_wr, ifid_wr, ifid_flush, idex_flush, mdu_go, mdu_busy}
    if (r) begin
      e.ctrl = 6'b001100;
      e.sc = 0; e.fc = 0;
      busy_end = cyc;
      m_sc = 0; m_fc = 0;
    end else begin
      e.sc = perf(m_sc);
      e.fc = perf(m_fc);
      if (br)         e.ctrl = {4'b1111, 1'b0, busy};
      else if (stall) e.ctrl = {4'b0001, 1'b0, busy};
      else            e.ctrl = {4'b1100, st, busy};
      if (!br && !stall && st) busy_end = cyc + N;
      if (stall && !br) m_sc++;
      if (br) m_fc++;
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {pc_wr, ifid_wr, ifid_flush, idex_flush, mdu_go, mdu_busy};
        checks++;
        if (act !== e.ctrl) begin
          fails++;
          $display("FAIL ctrl t=%0t got=%b want=%b", $time, act, e.ctrl);
        end
        checks++;
        if (stall_cycles !== e.sc) begin
          fails++;
          $display("FAIL stall_cycles got=%0d want=%0d", stall_cycles, e.sc);
        end
        checks++;
        if (flush_count !== e.fc) begin
          fails++;
          $display("FAIL flush_count got=%0d want=%0d", flush_count, e.fc);
        end
      end
    end
  end

  initial begin : stim
    rst = 1; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_mdu_start = 0; id_mdu_read = 0; ex_memrd = 0; ex_regrd = 0;
    branch_taken = 0;
    // reset for two cycles, then release
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // load-use, bubble, and r0 destination
    step(0, 8, 3, 1, 1, 0, 0, 1, 8, 0);
    step(0, 8, 3, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    // branch overrides an active load-use
    step(0, 5, 0, 0, 1, 0, 0, 1, 5, 1);
    step(0, 5, 0, 0, 1, 0, 0, 1, 5, 0);
    // branch with mult in ID must not start the MDU
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    // MDU start, mfhi held in ID until ready
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    repeat (N + 1) step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    // back-to-back start while busy, then reset mid-MDU
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    repeat (N + 1) step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    repeat (600) begin
      step($urandom_range(39) == 0,
           5'($urandom_range(3)), 5'($urandom_range(3)),
           1'($urandom), 1'($urandom),
           $urandom_range(5) == 0, $urandom_range(3) == 0,
           $urandom_range(2) == 0, 5'($urandom_range(3)),
           $urandom_range(7) == 0);
    end
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
